switch_decade_counter: RTL and testbench

- Upstream stage of the seven-segment display path: turns a raw mechanical push-switch into a clean 4-bit count for the binary-to-seven-segment decoder.
- Synchronises and debounces the switch, then advances a modulo-(MAX_COUNT+1) counter once per debounced release.
- Drives the decoder's 4-bit binary input directly and flags wrap-around for cascading a tens digit.

---
 rtl/switch_decade_counter.sv | 185 ++++++++++++++++++
 tb/tb_switch_decade_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_decade_counter.sv
// ============================================================================
// switch_decade_counter
//
// Upstream stage of the seven-segment display path. A raw mechanical
// push-switch is synchronised, debounced, and each debounced release
// advances a modulo-(MAX_COUNT+1) counter that drives the binary-to-
// seven-segment decoder directly.
//
// Optional feature macro: COUNTER_DOWN_SWITCH_EN
//   When defined, a second switch (i_Switch_2) with its own synchroniser and
//   debouncer decrements the count on release. When undefined the block is
//   increment-only and i_Switch_2 does not exist.
//
// Parameters:
//   DEBOUNCE_LIMIT  consecutive stable cycles needed to accept a new level (>= 2)
//   MAX_COUNT       highest count before wrap to 0 (1..15)
//
// Ports:
//   i_Clk            system clock, rising edge
//   i_Rst_L          synchronous active-low reset
//   i_Switch_1       raw increment switch, asynchronous, 1 = pressed
//   i_Switch_2       raw decrement switch (COUNTER_DOWN_SWITCH_EN only)
//   o_Binary_Number  registered count 0..MAX_COUNT
//   o_Carry          one-cycle pulse on an increment wrap MAX_COUNT -> 0
// ============================================================================

// ----------------------------------------------------------------------------
// switch_decade_counter_debounce
//
// One switch channel: two-flop synchroniser, debounce FSM holding the
// accepted level `stable`, and a falling-edge detector on that level.
//
// Ports:
//   i_Clk, i_Rst_L  clock and synchronous active-low reset
//   i_Switch        raw asynchronous switch level
//   o_Release       one-cycle pulse the cycle after `stable` falls 1 -> 0
// ----------------------------------------------------------------------------
module switch_decade_counter_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Release
);

    localparam int            CW   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

    typedef enum logic {
        STABLE,
        SETTLING
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    // NOTE: every register here uses <= so all flops sample the pre-edge
    // values; blocking assignments would collapse the synchroniser chain.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state    <= STABLE;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= i_Switch;
            sync2    <= sync1;
            stable_q <= stable;

            case (state)
                STABLE: begin
                    // First differing cycle counts as settling cycle 1, so the
                    // new level is accepted exactly DEBOUNCE_LIMIT cycles after
                    // sync2 first differs.
                    if (sync2 != stable) begin
                        state <= SETTLING;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                SETTLING: begin
                    if (sync2 == stable) begin
                        // Bounce back before the limit: discard the attempt.
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        stable <= sync2;
                        state  <= STABLE;
                        cnt    <= '0;
                    end else begin
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // stable_q is the registered copy of stable, so the pulse is exactly one
    // cycle wide and appears the cycle after the debounced level falls.
    assign o_Release = stable_q & ~stable;

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module switch_decade_counter #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int MAX_COUNT      = 9
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
`ifdef COUNTER_DOWN_SWITCH_EN
    input  logic       i_Switch_2,
`endif
    output logic [3:0] o_Binary_Number,
    output logic       o_Carry
);

    localparam logic [3:0] MAX = 4'(MAX_COUNT);

    logic inc_evt;
    logic dec_evt;

    switch_decade_counter_debounce #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_debounce_inc (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Switch  (i_Switch_1),
        .o_Release (inc_evt)
    );

`ifdef COUNTER_DOWN_SWITCH_EN
    switch_decade_counter_debounce #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_debounce_dec (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Switch  (i_Switch_2),
        .o_Release (dec_evt)
    );
`else
    assign dec_evt = 1'b0;
`endif

    // Simultaneous increment and decrement cancel. Carry is a pulse, so it is
    // cleared every cycle and only set on an increment wrap.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Binary_Number <= 4'd0;
            o_Carry         <= 1'b0;
        end else begin
            o_Carry <= 1'b0;
            if (inc_evt && !dec_evt) begin
                if (o_Binary_Number == MAX) begin
                    o_Binary_Number <= 4'd0;
                    o_Carry         <= 1'b1;
                end else begin
                    o_Binary_Number <= o_Binary_Number + 4'd1;
                end
            end else if (dec_evt && !inc_evt) begin
                if (o_Binary_Number == 4'd0) begin
                    o_Binary_Number <= MAX;
                end else begin
                    o_Binary_Number <= o_Binary_Number - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_decade_counter.sv
// ============================================================================
// tb_switch_decade_counter
//
// Directed bench for switch_decade_counter with DEBOUNCE_LIMIT=4, MAX_COUNT=9.
// Inputs change 1 time unit after a rising edge, so a new level is first
// sampled at the next edge (edge k). The count is then expected to change at
// edge k+6, i.e. visible after the 7th tick from the input change.
// ============================================================================
module tb_switch_decade_counter;

    localparam int DL = 4;
    localparam int MC = 9;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_Switch_1;
`ifdef COUNTER_DOWN_SWITCH_EN
    logic       i_Switch_2;
`endif
    logic [3:0] o_Binary_Number;
    logic       o_Carry;

    int n_checks = 0;
    int n_fail   = 0;

    switch_decade_counter #(
        .DEBOUNCE_LIMIT (DL),
        .MAX_COUNT      (MC)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Rst_L         (i_Rst_L),
        .i_Switch_1      (i_Switch_1),
`ifdef COUNTER_DOWN_SWITCH_EN
        .i_Switch_2      (i_Switch_2),
`endif
        .o_Binary_Number (o_Binary_Number),
        .o_Carry         (o_Carry)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic       sw;
        int         cycles;
        logic [3:0] cnt;
        logic       carry;
    } vec_t;

    vec_t vecs [40];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    // Clean press then release of the chosen switch (1 or 2), long enough for
    // the resulting count change to have landed.
    task automatic do_release(input int which);
        if (which == 1) i_Switch_1 = 1'b1;
`ifdef COUNTER_DOWN_SWITCH_EN
        else i_Switch_2 = 1'b1;
`endif
        tick(10);
        if (which == 1) i_Switch_1 = 1'b0;
`ifdef COUNTER_DOWN_SWITCH_EN
        else i_Switch_2 = 1'b0;
`endif
        tick(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Wrap table: ten press/release pairs from count 0. Each pair checks
        // that the press leaves the count alone, the count still holds 6 ticks
        // after release, changes on tick 7 (with carry only on 9->0), and the
        // carry is gone one cycle later.
        for (int r = 0; r < 10; r++) begin
            logic [3:0] cur;
            logic [3:0] nxt;
            cur = 4'(r);
            nxt = (r == MC) ? 4'd0 : 4'(r + 1);
            vecs[4*r + 0] = '{sw: 1'b1, cycles: 10, cnt: cur, carry: 1'b0};
            vecs[4*r + 1] = '{sw: 1'b0, cycles: 6,  cnt: cur, carry: 1'b0};
            vecs[4*r + 2] = '{sw: 1'b0, cycles: 1,  cnt: nxt, carry: (r == MC)};
            vecs[4*r + 3] = '{sw: 1'b0, cycles: 1,  cnt: nxt, carry: 1'b0};
        end

        i_Rst_L    = 1'b0;
        i_Switch_1 = 1'b0;
`ifdef COUNTER_DOWN_SWITCH_EN
        i_Switch_2 = 1'b0;
`endif

        // Reset held for 3 cycles while the switch toggles.
        for (int i = 0; i < 3; i++) begin
            i_Switch_1 = ~i_Switch_1;
            tick(1);
            check("reset_count", {4'd0, o_Binary_Number}, 8'd0);
            check("reset_carry", {7'd0, o_Carry}, 8'd0);
        end
        i_Switch_1 = 1'b0;
        i_Rst_L    = 1'b1;
        tick(1);
        check("post_reset_count", {4'd0, o_Binary_Number}, 8'd0);
        check("post_reset_carry", {7'd0, o_Carry}, 8'd0);
        tick(8);
        check("idle_count", {4'd0, o_Binary_Number}, 8'd0);

        // Clean releases through the wrap.
        for (int v = 0; v < 40; v++) begin
            i_Switch_1 = vecs[v].sw;
            tick(vecs[v].cycles);
            check($sformatf("wrap_count[%0d]", v), {4'd0, o_Binary_Number}, {4'd0, vecs[v].cnt});
            check($sformatf("wrap_carry[%0d]", v), {7'd0, o_Carry}, {7'd0, vecs[v].carry});
        end
        tick(4);

        // Bounce on release: low/high twice at 2-cycle spacing, then settle low.
        i_Switch_1 = 1'b1;
        tick(10);
        check("bounce_press", {4'd0, o_Binary_Number}, 8'd0);
        i_Switch_1 = 1'b0; tick(2);
        i_Switch_1 = 1'b1; tick(2);
        i_Switch_1 = 1'b0; tick(2);
        i_Switch_1 = 1'b1; tick(2);
        check("bounce_glitch", {4'd0, o_Binary_Number}, 8'd0);
        i_Switch_1 = 1'b0;
        tick(6);
        check("bounce_before", {4'd0, o_Binary_Number}, 8'd0);
        tick(1);
        check("bounce_after", {4'd0, o_Binary_Number}, 8'd1);
        check("bounce_carry", {7'd0, o_Carry}, 8'd0);
        tick(20);
        check("bounce_single", {4'd0, o_Binary_Number}, 8'd1);

        // Bring count to 5, then reset in the middle of a release debounce.
        for (int i = 0; i < 4; i++) do_release(1);
        check("pre_abort_count", {4'd0, o_Binary_Number}, 8'd5);
        i_Switch_1 = 1'b1;
        tick(10);
        i_Switch_1 = 1'b0;
        tick(4);
        i_Rst_L = 1'b0;
        tick(1);
        check("abort_reset_count", {4'd0, o_Binary_Number}, 8'd0);
        check("abort_reset_carry", {7'd0, o_Carry}, 8'd0);
        i_Rst_L = 1'b1;
        tick(1);
        check("abort_release_count", {4'd0, o_Binary_Number}, 8'd0);
        tick(20);
        check("abort_no_increment", {4'd0, o_Binary_Number}, 8'd0);
        check("abort_no_carry", {7'd0, o_Carry}, 8'd0);

`ifdef COUNTER_DOWN_SWITCH_EN
        // Decrement from 0 wraps to MAX_COUNT without carry.
        i_Switch_2 = 1'b1;
        tick(10);
        i_Switch_2 = 1'b0;
        tick(6);
        check("dec_before", {4'd0, o_Binary_Number}, 8'd0);
        tick(1);
        check("dec_wrap_count", {4'd0, o_Binary_Number}, 8'd9);
        check("dec_wrap_carry", {7'd0, o_Carry}, 8'd0);
        tick(3);
        for (int i = 0; i < 5; i++) do_release(2);
        check("dec_to_4", {4'd0, o_Binary_Number}, 8'd4);

        // Simultaneous releases cancel.
        i_Switch_1 = 1'b1;
        i_Switch_2 = 1'b1;
        tick(10);
        i_Switch_1 = 1'b0;
        i_Switch_2 = 1'b0;
        tick(7);
        check("both_count", {4'd0, o_Binary_Number}, 8'd4);
        check("both_carry", {7'd0, o_Carry}, 8'd0);
        tick(5);
        check("both_hold", {4'd0, o_Binary_Number}, 8'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
